// File: rtl/rob_multi_commit.sv
`default_nettype none
// ============================================================================
// Module   : rob_multi_commit
// Brief    : Reorder buffer for the out-of-order RV32I core. Entries are
//            allocated in program order at dispatch, marked finished by
//            NUM_WB result buses, and retired in order, up to COMMIT_W per
//            cycle. A branch whose resolved direction disagrees with its
//            prediction empties the buffer and raises a one-cycle flush
//            carrying the restart PC. Retiring stores are reported to the LSB.
// Ports    : clk_in/rst_in/rdy_in      clock, async active-high reset, enable
//            disp_*                    dispatch request and entry payload
//            full/free_id/head_id      occupancy and allocation status
//            q0_*/q1_*                 operand readiness/value lookup (comb)
//            wb_valid/wb_id/wb_value   writeback channels (packed per channel)
//            cm_*                      registered REG-commit slots to the RF
//            st_commit/st_commit_id    registered store-retire pulse
//            flush/flush_pc            registered mispredict pulse + PC
// Revision : 1.0 - initial release
// ============================================================================
module rob_multi_commit #(
    parameter int ID_BITS  = 5,
    parameter int NUM_WB   = 2,
    parameter int COMMIT_W = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       disp_valid,
    input  logic [1:0]                 disp_type,
    input  logic [4:0]                 disp_rd,
    input  logic                       disp_done,
    input  logic [31:0]                disp_value,
    input  logic                       disp_pred,
    input  logic [31:0]                disp_alt_pc,
    output logic                       full,
    output logic [ID_BITS-1:0]         free_id,
    output logic [ID_BITS-1:0]         head_id,
    input  logic [ID_BITS-1:0]         q0_id,
    input  logic [ID_BITS-1:0]         q1_id,
    output logic                       q0_ready,
    output logic                       q1_ready,
    output logic [31:0]                q0_value,
    output logic [31:0]                q1_value,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*ID_BITS-1:0]  wb_id,
    input  logic [NUM_WB*32-1:0]       wb_value,
    output logic [COMMIT_W-1:0]        cm_valid,
    output logic [COMMIT_W*5-1:0]      cm_rd,
    output logic [COMMIT_W*ID_BITS-1:0] cm_id,
    output logic [COMMIT_W*32-1:0]     cm_value,
    output logic                       st_commit,
    output logic [ID_BITS-1:0]         st_commit_id,
    output logic                       flush,
    output logic [31:0]                flush_pc
);

    localparam int c_depth = 1 << ID_BITS;
    localparam int c_cnt_w = ID_BITS + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(c_depth);

    localparam logic [1:0] c_type_reg = 2'd0;
    localparam logic [1:0] c_type_st  = 2'd1;
    localparam logic [1:0] c_type_br  = 2'd2;
    localparam logic [1:0] c_type_nop = 2'd3;

    // Control state (reset)
    logic [ID_BITS-1:0] head_q, head_d;
    logic [ID_BITS-1:0] tail_q, tail_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic [c_depth-1:0] valid_q, valid_d;
    logic [c_depth-1:0] done_q, done_d;

    // Entry payload (no reset; only meaningful while valid)
    logic [1:0]         type_q   [c_depth];
    logic [4:0]         rd_q     [c_depth];
    logic [31:0]        value_q  [c_depth];
    logic [31:0]        alt_pc_q [c_depth];
    logic [c_depth-1:0] pred_q;

    // Registered outputs; slot storage is sized for two slots regardless of COMMIT_W
    logic [1:0]           cm_valid_q;
    logic [9:0]           cm_rd_q;
    logic [2*ID_BITS-1:0] cm_id_q;
    logic [63:0]          cm_value_q;
    logic                 st_commit_q;
    logic [ID_BITS-1:0]   st_commit_id_q;
    logic                 flush_q;
    logic [31:0]          flush_pc_q;

    logic [ID_BITS-1:0] w_head1;
    logic [1:0]         w_type_h;
    logic [1:0]         w_type_h1;
    logic               w_full;
    logic               w_disp_acc;
    logic               w_c0;
    logic               w_c1;
    logic               w_mispredict;
    logic [c_cnt_w-1:0] w_n_ret;

    assign w_head1   = head_q + ID_BITS'(1);
    assign w_type_h  = type_q[head_q];
    assign w_type_h1 = type_q[w_head1];
    // No look-ahead: a retire in the same cycle does not free a slot early.
    assign w_full     = (count_q == c_full_cnt);
    assign w_disp_acc = disp_valid && !w_full && !flush_q;

    assign w_c0 = !flush_q && (count_q != '0) && done_q[head_q];
    // Second slot only pairs plain entries, so any ST/BR retires alone in slot 0.
    assign w_c1 = (COMMIT_W == 2) && w_c0 && (count_q >= c_cnt_w'(2)) && done_q[w_head1]
                  && ((w_type_h  == c_type_reg) || (w_type_h  == c_type_nop))
                  && ((w_type_h1 == c_type_reg) || (w_type_h1 == c_type_nop));

    // For BR entries, bit 0 of the result is the resolved taken flag.
    assign w_mispredict = w_c0 && (w_type_h == c_type_br)
                          && (value_q[head_q][0] != pred_q[head_q]);

    assign w_n_ret = c_cnt_w'(w_c0) + c_cnt_w'(w_c1);
    assign count_d = count_q + c_cnt_w'(w_disp_acc) - w_n_ret;
    assign tail_d  = w_disp_acc ? (tail_q + ID_BITS'(1)) : tail_q;

    always_comb begin
        head_d = head_q;
        if (w_c1) begin
            head_d = head_q + ID_BITS'(2);
        end else if (w_c0) begin
            head_d = w_head1;
        end
    end

    // Next valid/done vectors: writeback, then allocation, then retire.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && valid_q[wb_id[k*ID_BITS +: ID_BITS]]) begin
                done_d[wb_id[k*ID_BITS +: ID_BITS]] = 1'b1;
            end
        end
        if (w_disp_acc) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = disp_done;
        end
        if (w_c0) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        if (w_c1) begin
            valid_d[w_head1] = 1'b0;
            done_d[w_head1]  = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            valid_q        <= '0;
            done_q         <= '0;
            cm_valid_q     <= '0;
            cm_rd_q        <= '0;
            cm_id_q        <= '0;
            cm_value_q     <= '0;
            st_commit_q    <= 1'b0;
            st_commit_id_q <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else if (rdy_in) begin
            cm_valid_q  <= '0;
            st_commit_q <= 1'b0;
            flush_q     <= 1'b0;
            if (w_mispredict) begin
                // Drop every younger entry along with this cycle's dispatch/writebacks.
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
                valid_q    <= '0;
                done_q     <= '0;
                flush_q    <= 1'b1;
                flush_pc_q <= alt_pc_q[head_q];
            end else if (!flush_q) begin
                head_q  <= head_d;
                tail_q  <= tail_d;
                count_q <= count_d;
                valid_q <= valid_d;
                done_q  <= done_d;
                if (w_c0 && (w_type_h == c_type_reg)) begin
                    cm_valid_q[0]           <= 1'b1;
                    cm_rd_q[4:0]            <= rd_q[head_q];
                    cm_id_q[0 +: ID_BITS]   <= head_q;
                    cm_value_q[31:0]        <= value_q[head_q];
                end
                if (w_c0 && (w_type_h == c_type_st)) begin
                    st_commit_q    <= 1'b1;
                    st_commit_id_q <= head_q;
                end
                if (w_c1 && (w_type_h1 == c_type_reg)) begin
                    cm_valid_q[1]               <= 1'b1;
                    cm_rd_q[9:5]                <= rd_q[w_head1];
                    cm_id_q[ID_BITS +: ID_BITS] <= w_head1;
                    cm_value_q[63:32]           <= value_q[w_head1];
                end
            end
        end
    end

    // Payload writes; channel loop order makes the highest channel win on collisions.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_q && !w_mispredict) begin
            if (w_disp_acc) begin
                type_q[tail_q]   <= disp_type;
                rd_q[tail_q]     <= disp_rd;
                value_q[tail_q]  <= disp_value;
                alt_pc_q[tail_q] <= disp_alt_pc;
                pred_q[tail_q]   <= disp_pred;
            end
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_valid[k] && valid_q[wb_id[k*ID_BITS +: ID_BITS]]) begin
                    value_q[wb_id[k*ID_BITS +: ID_BITS]] <= wb_value[k*32 +: 32];
                end
            end
        end
    end

    // Operand lookup: in-flight writeback beats same-cycle dispatch beats stored state.
    logic [ID_BITS-1:0] w_qid   [2];
    logic [1:0]         w_q_rdy;
    logic [31:0]        w_q_val [2];

    assign w_qid[0] = q0_id;
    assign w_qid[1] = q1_id;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_q_rdy[p] = done_q[w_qid[p]];
            w_q_val[p] = value_q[w_qid[p]];
            if (disp_valid && !w_full && (w_qid[p] == tail_q)) begin
                w_q_rdy[p] = disp_done;
                w_q_val[p] = disp_value;
            end
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_valid[k] && (wb_id[k*ID_BITS +: ID_BITS] == w_qid[p])) begin
                    w_q_rdy[p] = 1'b1;
                    w_q_val[p] = wb_value[k*32 +: 32];
                end
            end
        end
    end

    assign q0_ready = w_q_rdy[0];
    assign q1_ready = w_q_rdy[1];
    assign q0_value = w_q_val[0];
    assign q1_value = w_q_val[1];

    assign full         = w_full;
    assign free_id      = tail_q;
    assign head_id      = head_q;
    assign cm_valid     = cm_valid_q[COMMIT_W-1:0];
    assign cm_rd        = cm_rd_q[COMMIT_W*5-1:0];
    assign cm_id        = cm_id_q[COMMIT_W*ID_BITS-1:0];
    assign cm_value     = cm_value_q[COMMIT_W*32-1:0];
    assign st_commit    = st_commit_q;
    assign st_commit_id = st_commit_id_q;
    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_rob_multi_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_multi_commit
// Brief    : Directed bench for rob_multi_commit: paired commit, full/wrap,
//            mispredict flush, store retire, query bypass, enable hold and
//            asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rob_multi_commit;

    localparam int ID_BITS  = 5;
    localparam int NUM_WB   = 2;
    localparam int COMMIT_W = 2;

    localparam logic [1:0] T_REG = 2'd0;
    localparam logic [1:0] T_ST  = 2'd1;
    localparam logic [1:0] T_BR  = 2'd2;
    localparam logic [1:0] T_NOP = 2'd3;

    logic                       clk_in = 1'b0;
    logic                       rst_in;
    logic                       rdy_in;
    logic                       disp_valid;
    logic [1:0]                 disp_type;
    logic [4:0]                 disp_rd;
    logic                       disp_done;
    logic [31:0]                disp_value;
    logic                       disp_pred;
    logic [31:0]                disp_alt_pc;
    logic                       full;
    logic [ID_BITS-1:0]         free_id;
    logic [ID_BITS-1:0]         head_id;
    logic [ID_BITS-1:0]         q0_id;
    logic [ID_BITS-1:0]         q1_id;
    logic                       q0_ready;
    logic                       q1_ready;
    logic [31:0]                q0_value;
    logic [31:0]                q1_value;
    logic [NUM_WB-1:0]          wb_valid;
    logic [NUM_WB*ID_BITS-1:0]  wb_id;
    logic [NUM_WB*32-1:0]       wb_value;
    logic [COMMIT_W-1:0]        cm_valid;
    logic [COMMIT_W*5-1:0]      cm_rd;
    logic [COMMIT_W*ID_BITS-1:0] cm_id;
    logic [COMMIT_W*32-1:0]     cm_value;
    logic                       st_commit;
    logic [ID_BITS-1:0]         st_commit_id;
    logic                       flush;
    logic [31:0]                flush_pc;

    int n_tests = 0;
    int n_fail  = 0;

    rob_multi_commit #(
        .ID_BITS (ID_BITS),
        .NUM_WB  (NUM_WB),
        .COMMIT_W(COMMIT_W)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .disp_valid  (disp_valid),
        .disp_type   (disp_type),
        .disp_rd     (disp_rd),
        .disp_done   (disp_done),
        .disp_value  (disp_value),
        .disp_pred   (disp_pred),
        .disp_alt_pc (disp_alt_pc),
        .full        (full),
        .free_id     (free_id),
        .head_id     (head_id),
        .q0_id       (q0_id),
        .q1_id       (q1_id),
        .q0_ready    (q0_ready),
        .q1_ready    (q1_ready),
        .q0_value    (q0_value),
        .q1_value    (q1_value),
        .wb_valid    (wb_valid),
        .wb_id       (wb_id),
        .wb_value    (wb_value),
        .cm_valid    (cm_valid),
        .cm_rd       (cm_rd),
        .cm_id       (cm_id),
        .cm_value    (cm_value),
        .st_commit   (st_commit),
        .st_commit_id(st_commit_id),
        .flush       (flush),
        .flush_pc    (flush_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clr_in();
        disp_valid  = 1'b0;
        disp_type   = T_REG;
        disp_rd     = '0;
        disp_done   = 1'b0;
        disp_value  = '0;
        disp_pred   = 1'b0;
        disp_alt_pc = '0;
        wb_valid    = '0;
        wb_id       = '0;
        wb_value    = '0;
    endtask

    task automatic set_disp(input logic [1:0] t, input logic [4:0] rd, input logic done,
                            input logic [31:0] val, input logic pred, input logic [31:0] alt);
        disp_valid  = 1'b1;
        disp_type   = t;
        disp_rd     = rd;
        disp_done   = done;
        disp_value  = val;
        disp_pred   = pred;
        disp_alt_pc = alt;
    endtask

    task automatic disp(input logic [1:0] t, input logic [4:0] rd, input logic done,
                        input logic [31:0] val, input logic pred, input logic [31:0] alt);
        set_disp(t, rd, done, val, pred, alt);
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic set_wb(input logic [1:0] v, input logic [4:0] id0, input logic [31:0] v0,
                          input logic [4:0] id1, input logic [31:0] v1);
        wb_valid = v;
        wb_id    = {id1, id0};
        wb_value = {v1, v0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        q0_id  = '0;
        q1_id  = '0;
        clr_in();
        tick();
        tick();
        rst_in = 1'b0;

        // ---- reset state
        chk("rst full",     64'(full), 64'd0);
        chk("rst free_id",  64'(free_id), 64'd0);
        chk("rst head_id",  64'(head_id), 64'd0);
        chk("rst cm_valid", 64'(cm_valid), 64'd0);
        chk("rst cm_value", cm_value, 64'd0);
        chk("rst st",       64'(st_commit), 64'd0);
        chk("rst st_id",    64'(st_commit_id), 64'd0);
        chk("rst flush",    64'(flush), 64'd0);
        chk("rst flush_pc", 64'(flush_pc), 64'd0);

        // ---- paired commit, writebacks out of order
        disp(T_REG, 5'd1, 1'b0, 32'h0, 1'b0, 32'h0);
        disp(T_REG, 5'd2, 1'b0, 32'h0, 1'b0, 32'h0);
        disp(T_REG, 5'd3, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t1 free_id", 64'(free_id), 64'd3);
        chk("t1 head_id", 64'(head_id), 64'd0);
        set_wb(2'b11, 5'd1, 32'h22, 5'd0, 32'h11);
        tick();
        clr_in();
        chk("t1 cm early", 64'(cm_valid), 64'd0);
        tick();
        chk("t1 cm_valid", 64'(cm_valid), 64'h3);
        chk("t1 cm_rd",    64'(cm_rd), 64'h041);
        chk("t1 cm_value", cm_value, 64'h0000_0022_0000_0011);
        chk("t1 cm_id",    64'(cm_id), 64'h020);
        chk("t1 head",     64'(head_id), 64'd2);
        tick();
        chk("t1 pulse",    64'(cm_valid), 64'd0);
        chk("t1 head hold", 64'(head_id), 64'd2);
        set_wb(2'b01, 5'd2, 32'h33, 5'd0, 32'h0);
        tick();
        clr_in();
        tick();
        chk("t1 drain valid", 64'(cm_valid), 64'h1);
        chk("t1 drain val",   64'(cm_value[31:0]), 64'h33);
        chk("t1 drain rd",    64'(cm_rd[4:0]), 64'd3);
        chk("t1 drain head",  64'(head_id), 64'd3);

        // ---- async reset between edges, then fill to full
        rst_in = 1'b1;
        #2;
        rst_in = 1'b0;
        chk("t2 rst head", 64'(head_id), 64'd0);
        chk("t2 rst tail", 64'(free_id), 64'd0);
        for (int i = 0; i < 32; i++) begin
            disp(T_REG, 5'(i), 1'b0, 32'h0, 1'b0, 32'h0);
        end
        chk("t2 full",      64'(full), 64'd1);
        chk("t2 wrap tail", 64'(free_id), 64'd0);
        set_disp(T_REG, 5'd31, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("t2 33rd tail", 64'(free_id), 64'd0);
        chk("t2 33rd full", 64'(full), 64'd1);
        set_wb(2'b01, 5'd0, 32'h55, 5'd0, 32'h0);
        tick();
        chk("t2 A full", 64'(full), 64'd1);
        chk("t2 A cm",   64'(cm_valid), 64'd0);
        set_wb(2'b01, 5'd1, 32'h66, 5'd0, 32'h0);
        tick();
        chk("t2 B cm",   64'(cm_valid), 64'h1);
        chk("t2 B val",  64'(cm_value[31:0]), 64'h55);
        chk("t2 B head", 64'(head_id), 64'd1);
        chk("t2 B tail", 64'(free_id), 64'd0);
        chk("t2 B full", 64'(full), 64'd0);
        wb_valid = '0;
        set_disp(T_REG, 5'd9, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("t2 C cm",   64'(cm_valid), 64'h1);
        chk("t2 C val",  64'(cm_value[31:0]), 64'h66);
        chk("t2 C id",   64'(cm_id[4:0]), 64'd1);
        chk("t2 C head", 64'(head_id), 64'd2);
        chk("t2 C tail", 64'(free_id), 64'd1);
        chk("t2 C full", 64'(full), 64'd0);
        tick();
        chk("t2 D full", 64'(full), 64'd1);
        chk("t2 D tail", 64'(free_id), 64'd2);
        clr_in();

        // ---- mispredicted branch at head
        rst_in = 1'b1;
        #2;
        rst_in = 1'b0;
        disp(T_BR,  5'd0, 1'b0, 32'h0,  1'b1, 32'h1000);
        disp(T_REG, 5'd5, 1'b1, 32'h77, 1'b0, 32'h0);
        set_wb(2'b01, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        set_wb(2'b10, 5'd0, 32'h0, 5'd1, 32'h99);
        set_disp(T_REG, 5'd6, 1'b1, 32'h88, 1'b0, 32'h0);
        tick();
        chk("t3 flush",    64'(flush), 64'd1);
        chk("t3 flush_pc", 64'(flush_pc), 64'h1000);
        chk("t3 cm",       64'(cm_valid), 64'd0);
        chk("t3 head",     64'(head_id), 64'd0);
        chk("t3 tail",     64'(free_id), 64'd0);
        chk("t3 full",     64'(full), 64'd0);
        wb_valid = '0;
        tick();
        chk("t3 flush drop", 64'(flush), 64'd0);
        chk("t3 no disp",    64'(free_id), 64'd0);
        clr_in();
        tick();
        chk("t3 empty cm",   64'(cm_valid), 64'd0);

        // ---- store retires alone, REG follows next cycle
        disp(T_NOP, 5'd0, 1'b1, 32'h0, 1'b0, 32'h0);
        disp(T_ST,  5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t4 nop cm", 64'(cm_valid), 64'd0);
        chk("t4 nop st", 64'(st_commit), 64'd0);
        disp(T_REG, 5'd7, 1'b1, 32'h44, 1'b0, 32'h0);
        set_wb(2'b01, 5'd1, 32'hDEAD, 5'd0, 32'h0);
        tick();
        clr_in();
        tick();
        chk("t4 st",     64'(st_commit), 64'd1);
        chk("t4 st_id",  64'(st_commit_id), 64'd1);
        chk("t4 st cm",  64'(cm_valid), 64'd0);
        tick();
        chk("t4 reg cm", 64'(cm_valid), 64'h1);
        chk("t4 reg rd", 64'(cm_rd[4:0]), 64'd7);
        chk("t4 reg val", 64'(cm_value[31:0]), 64'h44);
        chk("t4 reg id", 64'(cm_id[4:0]), 64'd2);
        chk("t4 st drop", 64'(st_commit), 64'd0);
        chk("t4 head",   64'(head_id), 64'd3);

        // ---- query bypass paths (head = tail = 3, empty)
        q0_id = 5'd4;
        q1_id = 5'd3;
        set_wb(2'b11, 5'd4, 32'h1, 5'd4, 32'hABCD);
        set_disp(T_REG, 5'd1, 1'b1, 32'd7, 1'b0, 32'h0);
        #1;
        chk("t5 q0 rdy", 64'(q0_ready), 64'd1);
        chk("t5 q0 val", 64'(q0_value), 64'hABCD);
        chk("t5 q1 rdy", 64'(q1_ready), 64'd1);
        chk("t5 q1 val", 64'(q1_value), 64'd7);
        wb_valid = '0;
        q0_id    = 5'd5;
        #1;
        chk("t5 q0 none", 64'(q0_ready), 64'd0);
        disp_valid = 1'b0;
        #1;
        chk("t5 q1 none", 64'(q1_ready), 64'd0);
        clr_in();

        // ---- enable low holds state
        disp(T_REG, 5'd4, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("t6 tail", 64'(free_id), 64'd4);
        rdy_in = 1'b0;
        set_wb(2'b11, 5'd3, 32'h10, 5'd3, 32'h20);
        set_disp(T_REG, 5'd2, 1'b1, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6 hold tail", 64'(free_id), 64'd4);
            chk("t6 hold head", 64'(head_id), 64'd3);
            chk("t6 hold cm",   64'(cm_valid), 64'd0);
        end
        rdy_in = 1'b1;
        clr_in();
        q0_id = 5'd3;
        #1;
        chk("t6 no done", 64'(q0_ready), 64'd0);
        set_wb(2'b11, 5'd3, 32'h10, 5'd3, 32'h20);
        tick();
        clr_in();
        #1;
        chk("t6 stored rdy", 64'(q0_ready), 64'd1);
        chk("t6 stored val", 64'(q0_value), 64'h20);
        tick();
        chk("t6 cm",     64'(cm_valid), 64'h1);
        chk("t6 cm val", 64'(cm_value[31:0]), 64'h20);
        chk("t6 head",   64'(head_id), 64'd4);
        rdy_in = 1'b0;
        tick();
        chk("t6 out hold", 64'(cm_valid), 64'h1);
        rdy_in = 1'b1;
        tick();
        chk("t6 out drop", 64'(cm_valid), 64'd0);

        // ---- reset in the middle of a commit burst
        set_disp(T_REG, 5'd8, 1'b1, 32'h5A, 1'b0, 32'h0);
        tick();
        tick();
        tick();
        chk("t7 burst cm",  64'(cm_valid), 64'h1);
        chk("t7 burst val", 64'(cm_value[31:0]), 64'h5A);
        #2;
        rst_in = 1'b1;
        #1;
        chk("t7 rst cm",    64'(cm_valid), 64'd0);
        chk("t7 rst val",   cm_value, 64'd0);
        chk("t7 rst rd",    64'(cm_rd), 64'd0);
        chk("t7 rst tail",  64'(free_id), 64'd0);
        chk("t7 rst head",  64'(head_id), 64'd0);
        chk("t7 rst full",  64'(full), 64'd0);
        chk("t7 rst st",    64'(st_commit), 64'd0);
        chk("t7 rst flush", 64'(flush), 64'd0);
        clr_in();
        tick();
        rst_in = 1'b0;
        tick();
        chk("t7 post tail", 64'(free_id), 64'd0);
        chk("t7 post cm",   64'(cm_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
